// File: rtl/machine_pkg.sv
// Shared types and constants for the change dispenser: FSM states,
// change codes and coin selectors.
package machine_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_WAIT_ACK,
    S_FAULT
  } state_t;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;
  localparam logic [1:0] CHG_15   = 2'b11;

  localparam logic COIN5  = 1'b0;
  localparam logic COIN10 = 1'b1;

endpackage

// File: rtl/disp_timer.sv
// Loadable down-counter shared by the eject strobe and the acknowledge window.
// The count holds at zero until it is reloaded.
module disp_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (load)             cnt <= val;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out change one coin at a time through a pulse/acknowledge handshake,
// greedy 10-then-5. Optional stats counters: CHANGE_DISPENSER_STATS_EN.
module change_dispenser
  import machine_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 6,
  parameter int INIT_C5   = 20,
  parameter int INIT_C10  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             done,
  input  logic [1:0]       change,
  input  logic             coin_seen,
  input  logic             refill,
  input  logic             clear_fault,
  output logic             eject5,
  output logic             eject10,
  output logic             busy,
  output logic             paid,
  output logic             fault,
  output logic [CNT_W-1:0] stock5,
  output logic [CNT_W-1:0] stock10
`ifdef CHANGE_DISPENSER_STATS_EN
  ,
  output logic [15:0]      coins_out,
  output logic [7:0]       faults_cnt
`endif
);

  localparam int TMAX = (PULSE_LEN > TIMEOUT) ? PULSE_LEN : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] TO_LD    = TW'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] amt;
  logic       coin;

  logic          tload, ten, tzero;
  logic [TW-1:0] tval;
  logic          sel10, sel5, ack, jam;
  logic [1:0]    amt_left;

  assign sel10    = amt[1] && (stock10 != '0);
  assign sel5     = (amt != 2'd0) && (stock5 != '0);
  assign ack      = coin_seen && (state == S_PULSE || state == S_WAIT_ACK);
  assign jam      = (state == S_WAIT_ACK) && !coin_seen && tzero;
  assign amt_left = amt - ((coin == COIN10) ? 2'd2 : 2'd1);
  assign ten      = (state == S_PULSE) || (state == S_WAIT_ACK);

  // Timer loads the strobe length on coin choice, then the ack window.
  always_comb begin
    tload = 1'b0;
    tval  = PULSE_LD;
    if (state == S_SELECT) begin
      tload = 1'b1;
    end else if (state == S_PULSE && tzero && !coin_seen) begin
      tload = 1'b1;
      tval  = TO_LD;
    end
  end

  disp_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tload),
    .en    (ten),
    .val   (tval),
    .zero  (tzero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      amt     <= 2'd0;
      coin    <= COIN5;
      eject5  <= 1'b0;
      eject10 <= 1'b0;
      busy    <= 1'b0;
      paid    <= 1'b0;
      fault   <= 1'b0;
      stock5  <= CNT_W'(INIT_C5);
      stock10 <= CNT_W'(INIT_C10);
    end else begin
      paid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (refill) begin
            stock5  <= CNT_W'(INIT_C5);
            stock10 <= CNT_W'(INIT_C10);
          end
          if (done && change != CHG_NONE) begin
            amt   <= change;
            busy  <= 1'b1;
            state <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (sel10) begin
            coin    <= COIN10;
            eject10 <= 1'b1;
            state   <= S_PULSE;
          end else if (sel5) begin
            coin   <= COIN5;
            eject5 <= 1'b1;
            state  <= S_PULSE;
          end else begin
            fault <= 1'b1;
            state <= S_FAULT;
          end
        end
        S_PULSE, S_WAIT_ACK: begin
          if (coin_seen) begin
            eject5  <= 1'b0;
            eject10 <= 1'b0;
            amt     <= amt_left;
            if (coin == COIN10) stock10 <= stock10 - 1'b1;
            else                stock5  <= stock5 - 1'b1;
            if (amt_left == 2'd0) begin
              paid  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_SELECT;
            end
          end else if (tzero) begin
            if (state == S_PULSE) begin
              eject5  <= 1'b0;
              eject10 <= 1'b0;
              state   <= S_WAIT_ACK;
            end else begin
              fault <= 1'b1;
              state <= S_FAULT;
            end
          end
        end
        S_FAULT: begin
          if (refill) begin
            stock5  <= CNT_W'(INIT_C5);
            stock10 <= CNT_W'(INIT_C10);
          end
          if (clear_fault) begin
            amt   <= 2'd0;
            fault <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CHANGE_DISPENSER_STATS_EN
  logic fault_entry;
  assign fault_entry = ((state == S_SELECT) && !sel10 && !sel5) || jam;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coins_out  <= '0;
      faults_cnt <= '0;
    end else begin
      if (ack && coins_out != '1)          coins_out  <= coins_out + 1'b1;
      if (fault_entry && faults_cnt != '1) faults_cnt <= faults_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Transaction-scripted bench: a coin-level model predicts every cycle's outputs
// and a negedge process compares them against the dispenser.
module tb_change_dispenser;

  localparam int L    = 4;
  localparam int T    = 64;
  localparam int INIT = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       done, coin_seen, refill, clear_fault;
  logic [1:0] change;
  logic       eject5, eject10, busy, paid, fault;
  logic [5:0] stock5, stock10;

  change_dispenser #(
    .PULSE_LEN(L), .TIMEOUT(T), .CNT_W(6), .INIT_C5(INIT), .INIT_C10(INIT)
  ) dut (
    .clk(clk), .reset(reset), .done(done), .change(change),
    .coin_seen(coin_seen), .refill(refill), .clear_fault(clear_fault),
    .eject5(eject5), .eject10(eject10), .busy(busy), .paid(paid),
    .fault(fault), .stock5(stock5), .stock10(stock10)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;
  int m5, m10;
  bit mfault;
  logic exp_e5, exp_e10, exp_busy, exp_paid, exp_fault;
  int exp_s5, exp_s10;
  int paid_seen, e5_cyc, e10_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process against the model's expectations.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("eject5", 32'(eject5), 32'(exp_e5));
      chk("eject10", 32'(eject10), 32'(exp_e10));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("paid", 32'(paid), 32'(exp_paid));
      chk("fault", 32'(fault), 32'(exp_fault));
      chk("stock5", 32'(stock5), 32'(exp_s5));
      chk("stock10", 32'(stock10), 32'(exp_s10));
      chk("one_eject", 32'(eject5 & eject10), 32'd0);
      if (paid) paid_seen++;
      if (eject5) e5_cyc++;
      if (eject10) e10_cyc++;
    end
  end

  // Advance one clock; record what the outputs must show in the new cycle.
  task automatic step(input bit e5, input bit e10, input bit b, input bit p, input bit f);
    @(posedge clk); #1;
    exp_e5 = e5; exp_e10 = e10; exp_busy = b; exp_paid = p; exp_fault = f;
    exp_s5 = m5; exp_s10 = m10;
    done = 0; coin_seen = 0; refill = 0; clear_fault = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, mfault, 0, mfault);
  endtask

  task automatic drive_noise(input int noise);
    if (noise[0] && $urandom_range(0, 1) == 1) begin done = 1; change = 2'b01; end
    if (noise[1] && $urandom_range(0, 3) == 0) refill = 1;
  endtask

  function automatic int rand_ack();
    if ($urandom_range(0, 19) == 0) return -1;
    return int'($urandom_range(0, L + 6));
  endfunction

  // ack_at: index of the cycle (from the first strobe cycle) carrying coin_seen,
  // -1 for never, -2 to draw one at random per coin.
  task automatic pay(input logic [1:0] chg, input int ack_at, input int noise, input bit rf);
    int amt, a, c;
    bit acked;
    amt = chg;
    done = 1; change = chg;
    if (rf) begin refill = 1; m5 = INIT; m10 = INIT; end
    if (chg == 2'b00) begin step(0, 0, 0, 0, 0); return; end
    step(0, 0, 1, 0, 0);
    while (amt > 0) begin
      if (amt >= 2 && m10 > 0) c = 10;
      else if (m5 > 0)         c = 5;
      else begin step(0, 0, 1, 0, 1); mfault = 1; return; end
      a = (ack_at == -2) ? rand_ack() : ack_at;
      acked = 0;
      step(c == 5, c == 10, 1, 0, 0);
      for (int i = 0; i < L && !acked; i++) begin
        drive_noise(noise);
        if (a == i) begin coin_seen = 1; acked = 1; end
        else if (i < L - 1) step(c == 5, c == 10, 1, 0, 0);
      end
      if (!acked) begin
        step(0, 0, 1, 0, 0);
        for (int j = 0; j < T && !acked; j++) begin
          drive_noise(noise);
          if (a == L + j) begin coin_seen = 1; acked = 1; end
          else if (j < T - 1) step(0, 0, 1, 0, 0);
        end
        if (!acked) begin step(0, 0, 1, 0, 1); mfault = 1; return; end
      end
      amt -= c / 5;
      if (c == 10) m10--; else m5--;
      if (amt == 0) step(0, 0, 0, 1, 0);
      else          step(0, 0, 1, 0, 0);
    end
  endtask

  task automatic clear(input bit rf, input int linger);
    repeat (linger) begin
      if ($urandom_range(0, 1) == 1) coin_seen = 1;
      if ($urandom_range(0, 1) == 1) begin done = 1; change = 2'b11; end
      step(0, 0, 1, 0, 1);
    end
    clear_fault = 1;
    if (rf) begin refill = 1; m5 = INIT; m10 = INIT; end
    mfault = 0;
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; done = 0; change = 0; coin_seen = 0; refill = 0; clear_fault = 0;
    m5 = INIT; m10 = INIT; mfault = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_eject5", 32'(eject5), 0);
    chk("rst_eject10", 32'(eject10), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_paid", 32'(paid), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_stock5", 32'(stock5), 20);
    chk("rst_stock10", 32'(stock10), 20);
    @(posedge clk); #1 reset = 0;
    exp_e5 = 0; exp_e10 = 0; exp_busy = 0; exp_paid = 0; exp_fault = 0;
    exp_s5 = m5; exp_s10 = m10;
    chk_on = 1;
    idle(2);

    // 15 owed, acks two cycles after each strobe ends.
    paid_seen = 0; e5_cyc = 0; e10_cyc = 0;
    pay(2'b11, L + 2, 0, 0);
    idle(1);
    chk("t1_paid_pulses", 32'(paid_seen), 1);
    chk("t1_e10_cycles", 32'(e10_cyc), 4);
    chk("t1_e5_cycles", 32'(e5_cyc), 4);
    chk("t1_stock10", 32'(stock10), 19);
    chk("t1_stock5", 32'(stock5), 19);

    // Exhaust the 10s, then pay 10 with two 5s.
    repeat (19) begin pay(2'b10, 0, 0, 0); idle(1); end
    chk("t2_stock10_empty", 32'(stock10), 0);
    paid_seen = 0; e5_cyc = 0; e10_cyc = 0;
    pay(2'b10, L + 1, 0, 0);
    idle(1);
    chk("t2_stock5", 32'(stock5), 17);
    chk("t2_e5_cycles", 32'(e5_cyc), 8);
    chk("t2_e10_cycles", 32'(e10_cyc), 0);
    chk("t2_paid", 32'(paid_seen), 1);

    // Jammed mechanism: no acknowledge ever.
    pay(2'b01, -1, 0, 0);
    chk("t3_fault_model", 32'(mfault), 1);
    chk("t3_stock5_kept", 32'(stock5), 17);
    clear(0, 3);
    idle(2);

    // Zero change is ignored.
    paid_seen = 0;
    pay(2'b00, 0, 0, 0);
    idle(3);
    chk("t4_no_paid", 32'(paid_seen), 0);

    // done/refill noise while busy on a 10 payout.
    refill = 1; m5 = INIT; m10 = INIT; step(0, 0, 0, 0, 0);
    e5_cyc = 0; e10_cyc = 0;
    pay(2'b10, L + 3, 3, 0);
    idle(3);
    chk("t5_stock10", 32'(stock10), 19);
    chk("t5_stock5", 32'(stock5), 20);
    chk("t5_e10_cycles", 32'(e10_cyc), 4);
    chk("t5_e5_cycles", 32'(e5_cyc), 0);

    // Drain both stocks, then fault straight from coin selection.
    repeat (19) begin pay(2'b11, 1, 0, 0); end
    pay(2'b01, 2, 0, 0);
    idle(1);
    chk("t6_drained5", 32'(stock5), 0);
    chk("t6_drained10", 32'(stock10), 0);
    e5_cyc = 0; e10_cyc = 0;
    pay(2'b01, 0, 0, 0);
    idle(2);
    chk("t6_no_eject", 32'(e5_cyc + e10_cyc), 0);
    chk("t6_fault", 32'(fault), 1);
    clear(1, 1);
    idle(1);
    chk("t6_refill5", 32'(stock5), 20);
    chk("t6_refill10", 32'(stock10), 20);

    // Asynchronous reset in the middle of a strobe.
    done = 1; change = 2'b11;
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk_on = 0;
    #2 reset = 1;
    #1;
    chk("mid_rst_eject10", 32'(eject10), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_stock10", 32'(stock10), 20);
    @(posedge clk); #1 reset = 0;
    m5 = INIT; m10 = INIT; mfault = 0;
    exp_e5 = 0; exp_e10 = 0; exp_busy = 0; exp_paid = 0; exp_fault = 0;
    exp_s5 = m5; exp_s10 = m10;
    chk_on = 1;
    idle(2);

    // Random traffic.
    for (int k = 0; k < 150; k++) begin
      if (mfault) begin
        clear($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)));
      end else begin
        repeat ($urandom_range(0, 2)) begin
          if ($urandom_range(0, 1) == 1) coin_seen = 1;
          step(0, 0, 0, 0, 0);
        end
        pay(2'($urandom_range(0, 3)), -2, ($urandom_range(0, 1) == 1) ? 3 : 0,
            $urandom_range(0, 7) == 0);
      end
    end
    if (mfault) clear(1, 1);
    idle(3);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Consumer end of the vending machine's change interface. It captures the machine's `done`/`change` result and drives the coin-eject mechanism, one coin at a time, with a pulse/acknowledge handshake. It tracks 5- and 10-unit coin stock, pays change greedily and reports completion or a fault. It sits between the machine top level and the physical dispenser actuators.

Parameters:
- PULSE_LEN, 4: cycles each eject strobe is held high (minimum 1).
- TIMEOUT, 64: cycles allowed after the strobe ends for `coin_seen` to arrive.
- CNT_W, 6: width of each stock counter.
- INIT_C5, 20: 5-unit coin stock loaded at reset and on refill.
- INIT_C10, 20: 10-unit coin stock loaded at reset and on refill.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous active-high reset.
- done, input, 1: transaction-complete strobe from the machine.
- change, input, 2: change owed in 5-unit steps (00=0, 01=5, 10=10, 11=15); sampled with `done`.
- coin_seen, input, 1: mechanism acknowledge, one cycle per coin physically ejected.
- refill, input, 1: reload both stocks to INIT values.
- clear_fault, input, 1: leave FAULT.
- eject5, output, 1: eject one 5-unit coin.
- eject10, output, 1: eject one 10-unit coin.
- busy, output, 1: paying out; new requests are ignored.
- paid, output, 1: one-cycle pulse when the full amount has been dispensed.
- fault, output, 1: held high in FAULT.
- stock5, output, CNT_W: current 5-unit coin stock.
- stock10, output, CNT_W: current 10-unit coin stock.

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous, active-high.
- Reset values: state IDLE; eject5, eject10, busy, paid and fault all 0; stock5=INIT_C5, stock10=INIT_C10; amount register 0.
- States: IDLE, SELECT, PULSE, WAIT_ACK, FAULT (encoding in the package).
- IDLE:
  - `done`=1 with `change`!=0: amt<=change (2 bits, units of 5). SELECT next cycle; busy=1 from that cycle.
  - `done` with `change`=00: ignored; no busy, no paid.
- SELECT (1 cycle), greedy coin choice:
  - amt>=2 and stock10>0: coin=10.
  - else amt>=1 and stock5>0: coin=5.
  - else: FAULT (insufficient stock). Unpaid amt is retained.
- PULSE:
  - Selected eject output is high for exactly PULSE_LEN cycles, then WAIT_ACK.
  - Only one eject output is ever high at a time.
  - `coin_seen` during PULSE ends the strobe early and counts as the acknowledge.
- WAIT_ACK:
  - On `coin_seen`: amt -= 2 (10-coin) or 1 (5-coin); matching stock decrements by 1 in the same cycle.
  - If the new amt is 0: IDLE, with paid=1 for that one cycle and busy=0 the next cycle.
  - Otherwise SELECT.
  - No `coin_seen` within TIMEOUT cycles: FAULT (mechanism jam). That coin is not debited.
- FAULT:
  - fault=1, busy=1, no ejects.
  - `clear_fault` returns to IDLE, clears amt and drops fault the next cycle. The unpaid amount is discarded.
- `done` while busy: ignored; no queueing.
- `coin_seen` in IDLE, SELECT or FAULT: ignored.
- refill:
  - Honoured in IDLE or FAULT only; ignored elsewhere.
  - `refill` and `done` in the same IDLE cycle: both take effect; SELECT sees the refilled stock.
  - `refill` and `clear_fault` together: both take effect.
- Stock never underflows, because SELECT checks for >0 before choosing a coin.
- Mid-operation reset: outputs return to reset values immediately (asynchronous); the payout is abandoned.
- Worst case amt=3 (15): 10-coin then 5-coin, i.e. two full handshakes.

Optional Feature:
- Macro: CHANGE_DISPENSER_STATS_EN.
- When defined:
  - Adds outputs `coins_out` (16 bits, total coins ejected) and `faults_cnt` (8 bits, FAULT entries).
  - Both counters saturate at all-ones; both reset to 0 only on `reset`.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `machine_pkg` holds:
  - state enum;
  - `change` code constants (CHG_NONE/5/10/15);
  - coin-select constants (COIN5/COIN10).
- One natural sub-module, `disp_timer`: a loadable down-counter reused for the PULSE_LEN strobe and the TIMEOUT window, with a `zero` flag.
- The FSM and stock counters stay in the top.

Test Plan:
- Reset, then `done`=1 with change=11 and `coin_seen` 2 cycles after each strobe:
  - eject10 high for 4 cycles, then eject5 for 4 cycles;
  - paid pulses once; stock10=19, stock5=19.
- change=10 with stock10 forced to 0 (20 prior payouts of 10):
  - two eject5 strobes; stock5 drops by 2; paid=1.
- change=01 with no `coin_seen`:
  - eject5 strobe, then fault=1 exactly 64 cycles after the strobe ends; stock5 unchanged;
  - `clear_fault` then gives fault=0 and busy=0.
- `done` with change=00:
  - busy stays 0; no ejects; no paid.
- Second `done` (change=01) asserted while busy on a change=10 payout:
  - ignored; exactly one 10-coin ejected; stock5 unchanged.
- Stock at 0/0, `done` with change=01:
  - FAULT reached from SELECT with no eject asserted;
  - `refill` plus `clear_fault` restores stock to 20/20 and returns to IDLE.
